uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 2-flop synchronizer, 3-sample majority vote, FSM driving an external 9-bit SIPO.
// Optional parity checking is compiled in when UART_RX_PARITY_CHK_EN is defined; otherwise parity_err is tied low.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic reg_clk,
    input  logic reg_rst,
    input  logic baud_tick,
    input  logic rx_in,
    output logic shift,
    output logic serial_data_out,
    output logic load,
    output logic parity_err,
    output logic frame_err,
    output logic busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_MIDM1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_MIDP1 = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);

    generate
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_param
            $error("uart_rx_ctrl: OVERSAMPLE must be even and >= 8, PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          r_rx_m;
    logic          r_rx_s;
    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_bcnt;
    logic          r_armed;
    logic [2:0]    r_smp;
    logic          r_shift;
    logic          r_sdo;
    logic          r_load;
    logic          r_frame_err;
    logic          r_busy;

    logic          w_maj_data;
    logic          w_maj_stop;

    assign w_maj_data = maj3(r_smp[0], r_smp[1], r_smp[2]);
    // The stop decision uses the live MID+1 sample so the result is known on that very tick.
    assign w_maj_stop = maj3(r_smp[0], r_smp[1], r_rx_s);

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx_in;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
            r_armed     <= 1'b0;
            r_smp       <= '0;
            r_shift     <= 1'b0;
            r_sdo       <= 1'b0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shift     <= 1'b0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // armed only rises on a high line, so a held-low break never retriggers
                    if (r_rx_s) begin
                        r_armed <= 1'b1;
                    end
                    if (baud_tick && r_armed && !r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                        r_tcnt  <= '0;
                        r_armed <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if ((r_tcnt == T_MID) && r_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_tcnt  <= '0;
                        end else if (r_tcnt == T_LAST) begin
                            r_state <= S_DATA;
                            r_tcnt  <= '0;
                            r_bcnt  <= '0;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_tcnt == T_MIDM1) r_smp[0] <= r_rx_s;
                        if (r_tcnt == T_MID)   r_smp[1] <= r_rx_s;
                        if (r_tcnt == T_MIDP1) r_smp[2] <= r_rx_s;
                        if (r_tcnt == T_LAST) begin
                            r_shift <= 1'b1;
                            r_sdo   <= w_maj_data;
                            r_bcnt  <= r_bcnt + 1'b1;
                            r_tcnt  <= '0;
                            if (r_bcnt == 4'd8) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (r_tcnt == T_MIDM1) r_smp[0] <= r_rx_s;
                        if (r_tcnt == T_MID)   r_smp[1] <= r_rx_s;
                        if (r_tcnt == T_MIDP1) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_tcnt  <= '0;
                            if (w_maj_stop) begin
                                r_load <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_CHK_EN
    logic r_par;

    // Folds each shifted bit in the cycle after its shift pulse; reseeded while idle.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            r_par <= 1'b0;
        end else if (r_state == S_IDLE && !r_load) begin
            r_par <= (PARITY_ODD != 0);
        end else if (r_shift) begin
            r_par <= r_par ^ r_sdo;
        end
    end

    assign parity_err = r_load & r_par;
`else
    assign parity_err = 1'b0;
`endif

    assign shift           = r_shift;
    assign serial_data_out = r_sdo;
    assign load            = r_load;
    assign frame_err       = r_frame_err;
    assign busy            = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames, glitch rejection, break, majority vote, parity, mid-frame reset.
module tb_uart_rx_ctrl;

    localparam int OS  = 16;
    localparam int MID = OS / 2;

    logic reg_clk = 1'b0;
    logic reg_rst;
    logic baud_tick;
    logic rx_in;
    logic shift;
    logic serial_data_out;
    logic load;
    logic parity_err;
    logic frame_err;
    logic busy;

    int n_chk  = 0;
    int n_pass = 0;
    int tp     = 4;
    int tick_cnt = 0;
    int shift_cnt, load_cnt, perr_cnt, ferr_cnt, last_shift_tick;
    logic [8:0] got_bits;
    logic rst_arm  = 1'b0;
    logic rst_pend = 1'b0;
    logic rst_done = 1'b0;
    int   rst_seen = 0;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .PARITY_ODD(0)) u_dut (
        .reg_clk         (reg_clk),
        .reg_rst         (reg_rst),
        .baud_tick       (baud_tick),
        .rx_in           (rx_in),
        .shift           (shift),
        .serial_data_out (serial_data_out),
        .load            (load),
        .parity_err      (parity_err),
        .frame_err       (frame_err),
        .busy            (busy)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge reg_clk) begin
        if (baud_tick) tick_cnt <= tick_cnt + 1;
    end

    always @(negedge reg_clk) begin
        logic [3:0] idx;
        if (shift) begin
            idx = shift_cnt[3:0];
            if (shift_cnt < 9) got_bits[idx] = serial_data_out;
            shift_cnt++;
            last_shift_tick = tick_cnt;
        end
        if (load) begin
            load_cnt++;
            chk("load_latency", 32'(tick_cnt - last_shift_tick), 32'(MID + 2));
            chk("load_exclusive", 32'({shift, frame_err}), 32'd0);
            if (parity_err) perr_cnt++;
        end
        if (parity_err) chk("perr_with_load", 32'(load), 32'd1);
        if (frame_err) begin
            ferr_cnt++;
            chk("ferr_exclusive", 32'({shift, load}), 32'd0);
        end
    end

    // One baud period; the line value changes on the negedge that raises baud_tick.
    task automatic do_tick(input logic v);
        for (int i = 0; i < tp; i++) begin
            @(negedge reg_clk);
            if (rst_pend) begin
                rst_pend = 1'b0;
                rst_done = 1'b1;
                chk("rst_midframe_outs",
                    32'({shift, load, serial_data_out, parity_err, frame_err, busy}), 32'd0);
                reg_rst = 1'b0;
            end
            if (rst_arm && shift) begin
                rst_seen++;
                if (rst_seen == 4) begin
                    reg_rst  = 1'b1;
                    rst_pend = 1'b1;
                    rst_arm  = 1'b0;
                end
            end
            baud_tick = (i == 0);
            if (i == 0) rx_in = v;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1);
    endtask

    task automatic clear_mon();
        shift_cnt = 0;
        load_cnt  = 0;
        perr_cnt  = 0;
        ferr_cnt  = 0;
        got_bits  = '0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int gbit, input int grel, input int nbits);
        logic [10:0] seq;
        logic [3:0]  bi;
        logic        v;
        seq = {stp, par, d, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            for (int t = 0; t < OS; t++) begin
                bi = b[3:0];
                v  = seq[bi];
                if (b == gbit && t == grel) v = ~v;
                do_tick(v);
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [8:0] bits, input int nload,
                               input int nperr, input int nferr);
        chk({tag, "_shifts"}, 32'(shift_cnt), 32'd9);
        chk({tag, "_bits"}, 32'(got_bits), 32'(bits));
        chk({tag, "_loads"}, 32'(load_cnt), 32'(nload));
        chk({tag, "_perr"}, 32'(perr_cnt), 32'(nperr));
        chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(nferr));
    endtask

    initial begin
        reg_rst   = 1'b1;
        baud_tick = 1'b0;
        rx_in     = 1'b1;
        clear_mon();
        last_shift_tick = 0;
        repeat (3) @(negedge reg_clk);
        chk("reset_outs", 32'({shift, load, serial_data_out, parity_err, frame_err, busy}), 32'd0);
        reg_rst = 1'b0;
        idle(8);
        chk("idle_busy", 32'(busy), 32'd0);

        // 0xA5, even parity bit 0, good stop
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0, 11);
        idle(4);
        check_frame("a5", 9'h0A5, 1, 0, 0);
        chk("a5_busy_after", 32'(busy), 32'd0);

        // short low pulse rejected at the START midpoint
        idle(8);
        clear_mon();
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        chk("glitch_busy_start", 32'(busy), 32'd1);
        idle(12);
        chk("glitch_busy_end", 32'(busy), 32'd0);
        chk("glitch_shifts", 32'(shift_cnt), 32'd0);
        chk("glitch_loads", 32'(load_cnt), 32'd0);

        // bad stop followed by a held-low break, then recovery
        idle(8);
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0, 11);
        for (int i = 0; i < 40; i++) do_tick(1'b0);
        check_frame("brk", 9'h03C, 0, 0, 1);
        chk("brk_no_restart", 32'(busy), 32'd0);
        idle(8);
        clear_mon();
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0, 11);
        idle(4);
        check_frame("brk_recover", 9'h03C, 1, 0, 0);

        // data bit 1 pulled low only for the MID sample
        idle(8);
        clear_mon();
        send_frame(8'h03, 1'b0, 1'b1, 2, 9, 11);
        idle(4);
        check_frame("majority", 9'h003, 1, 0, 0);

        // 0x01 with parity bit 0 is a parity violation under even parity
        idle(8);
        clear_mon();
        send_frame(8'h01, 1'b0, 1'b1, -1, 0, 11);
        idle(4);
`ifdef UART_RX_PARITY_CHK_EN
        check_frame("parity", 9'h001, 1, 1, 0);
`else
        check_frame("parity", 9'h001, 1, 0, 0);
`endif

        // reset one cycle after the 4th shift abandons the frame
        idle(8);
        clear_mon();
        rst_seen = 0;
        rst_done = 1'b0;
        rst_arm  = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0, 5);
        idle(20);
        rst_arm = 1'b0;
        chk("rst_fired", 32'(rst_done), 32'd1);
        chk("rst_shifts", 32'(shift_cnt), 32'd4);
        chk("rst_loads", 32'(load_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        clear_mon();
        send_frame(8'hFF, 1'b0, 1'b1, -1, 0, 11);
        idle(4);
        check_frame("after_rst", 9'h0FF, 1, 0, 0);

        // baud_tick held high: one tick per clock
        tp = 1;
        idle(8);
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0, 11);
        idle(6);
        check_frame("tick_hi", 9'h05A, 1, 0, 0);
        chk("tick_hi_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
